seven_seg_multi: RTL and testbench

Parametrised multi-digit seven-segment driver. It converts a binary value to decimal (iterative double-dabble, one bit per clock) or to hexadecimal, then drives NUM_DIGITS active-low displays. Options cover leading-zero blanking and overflow indication. It sits between the HPS/fabric value registers and the board HEX pins, and replaces the single-digit, decimal-only 4-bit decoder.

---
 rtl/seven_seg_pkg.sv | 34 +++
 rtl/seg_hex_decode.sv | 14 +
 rtl/seven_seg_multi.sv | 159 +++++++++++++++
 tb/tb_seven_seg_multi.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multi-digit seven-segment driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Glyphs 0..F packed with digit 0 in the least significant 7 bits.
   localparam logic [16*7-1:0] SEG_TABLE = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0011000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit to active-low seven-segment decoder, all 16 codes.
module seg_hex_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Table lookup covers every input code, so no latch can be inferred.
   always_comb begin
      seg = SEG_TABLE[7*digit +: 7];
   end

endmodule

// File: rtl/seven_seg_multi.sv
// Multi-digit seven-segment driver: binary to decimal (double-dabble, one
// bit per clock) or hexadecimal, with leading-zero blanking and overflow.
//
// Handshake: load is accepted on a rising edge only while busy=0 (state is
// IDLE); value/hex_mode/blank_leading are sampled on that edge. Loads seen
// while busy=1 are dropped. done pulses for one cycle when seg_out and
// overflow take their new values; since the state is already IDLE in that
// cycle, a load held high there is accepted immediately.
module seven_seg_multi
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int BIN_WIDTH  = 20
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [BIN_WIDTH-1:0]    value,
   input  logic                    hex_mode,
   input  logic                    blank_leading,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic [7*NUM_DIGITS-1:0] seg_out,
   output state_t                  state_dbg
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int PAD_W = (BCD_W > BIN_WIDTH) ? BCD_W : BIN_WIDTH;
   localparam int CNT_W = $clog2(BIN_WIDTH);

   state_t                  state, state_next;
   logic                    load_accept, shift_en, latch_en;
   logic [BIN_WIDTH-1:0]    bin_q;
   logic [BCD_W-1:0]        bcd_q, bcd_adj, bcd_shift;
   logic                    shift_out;
   logic [CNT_W-1:0]        cnt_q;
   logic                    hex_q, blank_q, ovf_acc_q;
   logic [PAD_W-1:0]        bin_pad;
   logic                    hex_ovf, ovf_final;
   logic [BCD_W-1:0]        nib;
   logic [7*NUM_DIGITS-1:0] dec_seg, seg_next, seg_q;
   logic                    done_q, ovf_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state and datapath enables.
   always_comb begin
      state_next  = state;
      load_accept = 1'b0;
      shift_en    = 1'b0;
      latch_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load) begin
               load_accept = 1'b1;
               state_next  = hex_mode ? ST_LATCH : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_next = ST_LATCH;
         end
         ST_LATCH: begin
            latch_en   = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      shift_out = bcd_adj[BCD_W-1];
      bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
   end

   // Capture on accepted load, then shift one bit per SHIFT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         hex_q     <= 1'b0;
         blank_q   <= 1'b0;
         ovf_acc_q <= 1'b0;
      end else if (load_accept) begin
         bin_q     <= value;
         bcd_q     <= '0;
         cnt_q     <= '0;
         hex_q     <= hex_mode;
         blank_q   <= blank_leading;
         ovf_acc_q <= 1'b0;
      end else if (shift_en) begin
         bin_q <= {bin_q[BIN_WIDTH-2:0], 1'b0};
         bcd_q <= bcd_shift;
         cnt_q <= cnt_q + 1'b1;
         if (shift_out) ovf_acc_q <= 1'b1;
      end
   end

   // Digit source and overflow: hex uses the zero-padded captured value.
   always_comb begin
      bin_pad   = PAD_W'(bin_q);
      hex_ovf   = |(bin_pad >> BCD_W);
      ovf_final = hex_q ? hex_ovf : ovf_acc_q;
      nib       = hex_q ? bin_pad[BCD_W-1:0] : bcd_q;
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      seg_hex_decode u_dec (
         .digit (nib[4*g +: 4]),
         .seg   (dec_seg[7*g +: 7])
      );
   end

   // Blanking and overflow muxing; overflow dashes win over blanking.
   always_comb begin : blank_mux
      logic zero_run;
      zero_run = 1'b1;
      seg_next = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run & (nib[4*i +: 4] == 4'd0);
         if (ovf_final)                          seg_next[7*i +: 7] = SEG_DASH;
         else if (blank_q && zero_run && i != 0) seg_next[7*i +: 7] = SEG_BLANK;
         else                                    seg_next[7*i +: 7] = dec_seg[7*i +: 7];
      end
   end

   // Output registers update only in LATCH, so seg_out never shows partials.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q  <= '1;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= latch_en;
         if (latch_en) begin
            seg_q <= seg_next;
            ovf_q <= ovf_final;
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign done      = done_q;
   assign overflow  = ovf_q;
   assign seg_out   = seg_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_seven_seg_multi.sv
// Self-checking bench for seven_seg_multi at NUM_DIGITS=6, BIN_WIDTH=20.
module tb_seven_seg_multi;
   import seven_seg_pkg::*;

   localparam int ND = 6;
   localparam int BW = 20;
   localparam int SW = 7 * ND;
   localparam int W  = SW + 1;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010, S9 = 7'b0011000;
   localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110;
   localparam logic [6:0] SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;
   localparam logic [6:0] BLK = 7'b1111111, DSH = 7'b0111111;

   logic          clk = 1'b0;
   logic          reset, load, hex_mode, blank_leading;
   logic [BW-1:0] value;
   logic          busy, done, overflow;
   logic [SW-1:0] seg_out;
   state_t        state_dbg;

   logic [W-1:0]  exp_q[$];
   int            exp_cyc_q[$];
   int            cyc   = 0;
   int            total = 0;
   int            bad   = 0;
   logic [W-1:0]  mon_e;
   int            mon_c;
   int            c0;

   seven_seg_multi #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .value         (value),
      .hex_mode      (hex_mode),
      .blank_leading (blank_leading),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow),
      .seg_out       (seg_out),
      .state_dbg     (state_dbg)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drive one load at a negedge; optionally queue its expected result.
   task automatic issue(input logic [BW-1:0] v, input logic hx, input logic bl,
                        input logic [SW-1:0] es, input logic eo, input logic push);
      value = v; hex_mode = hx; blank_leading = bl; load = 1'b1;
      if (push) begin
         exp_q.push_back({eo, es});
         exp_cyc_q.push_back(cyc + 1 + (hx ? 1 : BW + 1));
      end
      @(negedge clk);
      load = 1'b0;
      check("busy_after_load", 64'(busy), 64'd1);
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL wait_done: got no done within 60 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Scoreboard monitor: every done pops one expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            check("seg_out", 64'(seg_out), 64'(mon_e[SW-1:0]));
            check("overflow", 64'(overflow), 64'(mon_e[SW]));
            check("done_cycle", 64'(cyc), 64'(mon_c));
         end
      end
   end

   initial begin
      reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0; blank_leading = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_seg", 64'(seg_out), 64'({SW{1'b1}}));
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      reset = 1'b0;
      @(negedge clk);

      // Decimal conversions.
      issue(20'd123456, 1'b0, 1'b0, {S1, S2, S3, S4, S5, S6}, 1'b0, 1'b1); wait_done();
      issue(20'd42, 1'b0, 1'b1, {BLK, BLK, BLK, BLK, S4, S2}, 1'b0, 1'b1); wait_done();
      issue(20'd42, 1'b0, 1'b0, {S0, S0, S0, S0, S4, S2}, 1'b0, 1'b1); wait_done();
      issue(20'd0, 1'b0, 1'b1, {BLK, BLK, BLK, BLK, BLK, S0}, 1'b0, 1'b1); wait_done();
      issue(20'd100, 1'b0, 1'b1, {BLK, BLK, BLK, S1, S0, S0}, 1'b0, 1'b1); wait_done();
      issue(20'd1000000, 1'b0, 1'b0, {ND{DSH}}, 1'b1, 1'b1); wait_done();
      issue(20'd999999, 1'b0, 1'b0, {ND{S9}}, 1'b0, 1'b1); wait_done();
      issue(20'd1048575, 1'b0, 1'b1, {ND{DSH}}, 1'b1, 1'b1); wait_done();

      // Hex conversions.
      issue(20'hABCDE, 1'b1, 1'b0, {S0, SA, SB, SC, SD, SE}, 1'b0, 1'b1); wait_done();
      issue(20'hABCDE, 1'b1, 1'b1, {BLK, SA, SB, SC, SD, SE}, 1'b0, 1'b1); wait_done();

      // Back-to-back decimal with load held; value changes while busy.
      c0 = cyc;
      value = 20'd123456; hex_mode = 1'b0; blank_leading = 1'b0; load = 1'b1;
      exp_q.push_back({1'b0, S1, S2, S3, S4, S5, S6}); exp_cyc_q.push_back(c0 + 22);
      exp_q.push_back({1'b0, S0, S0, S0, S0, S4, S2}); exp_cyc_q.push_back(c0 + 44);
      @(negedge clk);
      value = 20'd42;
      wait_until(c0 + 23);
      load = 1'b0;
      wait_done();

      // Back-to-back hex, period 2.
      c0 = cyc;
      value = 20'h00100; hex_mode = 1'b1; blank_leading = 1'b1; load = 1'b1;
      exp_q.push_back({1'b0, BLK, BLK, BLK, S1, S0, S0}); exp_cyc_q.push_back(c0 + 2);
      exp_q.push_back({1'b0, BLK, SF, SF, SF, SF, SF});   exp_cyc_q.push_back(c0 + 4);
      exp_q.push_back({1'b0, BLK, BLK, BLK, BLK, BLK, S0}); exp_cyc_q.push_back(c0 + 6);
      wait_until(c0 + 1); value = 20'hFFFFF;
      wait_until(c0 + 3); value = 20'h00000;
      wait_until(c0 + 5); load = 1'b0;
      wait_done();

      // A different load pulsed mid-SHIFT must be ignored.
      issue(20'd999999, 1'b0, 1'b0, {ND{S9}}, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      value = 20'hABCDE; hex_mode = 1'b1; blank_leading = 1'b1; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_done();

      // Reset mid-SHIFT aborts with no done and blank display.
      issue(20'd123456, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_seg", 64'(seg_out), 64'({SW{1'b1}}));
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_ovf", 64'(overflow), 64'd0);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_idle", 64'(state_dbg), 64'(ST_IDLE));
      check("abort_seg_hold", 64'(seg_out), 64'({SW{1'b1}}));

      repeat (5) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
